tug_game_ctrl: RTL
==================

// Module: tug_game_ctrl
// PURPOSE
// - Game sequencer for the tug-of-war board. Drives the LED mux select (led_control) and the
//   7-bit one-hot rope-position word (score).
// - Runs a round as: idle -> countdown -> play -> win blink -> idle.
// - Player buttons arrive debounced and synchronous to clk; timing is paced by a 1-cycle tick strobe.
// PARAMETERS
// - COUNT_TICKS  3  ticks spent in COUNTDOWN before play opens (>=1)
// - BLINK_TICKS  2  ticks per half-period of the win blink (>=1)
// - WIN_BLINKS   4  full on/off blink periods in WIN before returning to IDLE (>=1)
// PORTS
// - clk          in   1  system clock, all logic on rising edge
// - rst_n        in   1  synchronous reset, active-low
// - tick         in   1  timing strobe, one clk cycle wide
// - start        in   1  level; sampled only in IDLE
// - btn_a        in   1  player A button (debounced, synchronous); pulls rope toward score[6]
// - btn_b        in   1  player B button (debounced, synchronous); pulls rope toward score[0]
// - led_control  out  2  mux select: 00 dark, 01 countdown, 10 play, 11 win
// - score        out  7  one-hot rope position, or 0 during the win-blink off phase
// - winner       out  2  00 none, 01 A, 10 B; held from WIN entry until the next round starts
// - busy         out  1  1 in any state other than IDLE
// BEHAVIOUR
// Reset (rst_n=0 at clk edge; wins over every other input):
// - state=IDLE, led_control=00, score=7'b0001000, winner=00, busy=0.
// - All counters and button edge registers cleared.
// - Reset mid-round aborts the round in one edge.
// Button edges:
// - press_a = btn_a & ~btn_a_q (registered previous value); press_b likewise.
// - Edge registers update every cycle in every state, so a button held across a state change
//   does not produce a press.
// States (all outputs registered; a state's led_control appears the cycle after the transition edge):
// - IDLE: led_control=00, score=center 7'b0001000.
//   start=1 -> COUNTDOWN, clear tick counter, winner<=00.
// - COUNTDOWN: led_control=01, score=center.
//   Count tick pulses; on the COUNT_TICKS-th tick -> PLAY.
//   Presses are ignored here (no false-start penalty).
// - PLAY: led_control=10. Position pos (3 bits, 0..6) starts at 3.
//   - press_a only: pos+1. press_b only: pos-1. Both in the same cycle: no move. Neither: hold.
//   - score = 1<<pos, updated the cycle after the press edge.
//   - pos reaching 6 -> WIN with winner=01; pos reaching 0 -> WIN with winner=10.
//   - Never increment past 6 or decrement below 0 (unreachable because WIN is entered first).
//   - start is ignored.
// - WIN: led_control=11. Blink phase starts ON.
//   - score = 1<<pos in the ON phase, 0 in the OFF phase.
//   - Phase toggles every BLINK_TICKS ticks.
//   - After 2*WIN_BLINKS phases -> IDLE. score returns to center; winner is held.
//   - Buttons and start are ignored.
// Tick rules:
// - tick only advances COUNTDOWN/WIN counters; it has no effect in IDLE or PLAY.
// - A tick in the same cycle as a transition is not credited to the new state.
// Width rules:
// - Tick counters sized by $clog2(max(COUNT_TICKS, BLINK_TICKS) + 1).
// - Blink counter sized by $clog2(2*WIN_BLINKS + 1).
// TESTING
// - Reset: drive rst_n=0 mid-PLAY at pos=5 -> next edge led_control=00, score=0001000, winner=00, busy=0.
// - Countdown: start=1 in IDLE, 3 ticks with btn_a toggling -> led_control 01 then 10;
//   score stays 0001000 throughout.
// - A wins: in PLAY give 3 btn_a presses -> score 0010000, 0100000, 1000000; winner=01; led_control=11.
// - Simultaneous: btn_a and btn_b rise on the same cycle at pos=3 -> score stays 0001000.
//   A held button yields only one move.
// - Win blink: B wins (score=0000001); with BLINK_TICKS=2, WIN_BLINKS=4 -> score alternates
//   0000001/0000000 every 2 ticks for 8 phases, then IDLE, score=0001000, winner stays 10.
// - Ignored inputs: start pulses during PLAY/WIN and button presses in WIN/IDLE -> no state or score change.

Source files
------------

// File: rtl/tug_game_ctrl.sv
// Tug-of-war game sequencer: idle -> countdown -> play -> win blink -> idle.
// Drives the LED mux select, the one-hot rope position, the winner flag and busy.
module tug_game_ctrl #(
  parameter int unsigned COUNT_TICKS = 3,
  parameter int unsigned BLINK_TICKS = 2,
  parameter int unsigned WIN_BLINKS  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic       i_btn_a,
  input  logic       i_btn_b,
  output logic [1:0] o_led_control,
  output logic [6:0] o_score,
  output logic [1:0] o_winner,
  output logic       o_busy
);

  localparam int unsigned MaxTicks = (COUNT_TICKS > BLINK_TICKS) ? COUNT_TICKS : BLINK_TICKS;
  localparam int unsigned TickW    = $clog2(MaxTicks + 1);
  localparam int unsigned BlinkW   = $clog2(2 * WIN_BLINKS + 1);

  localparam logic [TickW-1:0]  CountLast = TickW'(COUNT_TICKS - 1);
  localparam logic [TickW-1:0]  BlinkLast = TickW'(BLINK_TICKS - 1);
  localparam logic [BlinkW-1:0] PhaseLast = BlinkW'(2 * WIN_BLINKS - 1);
  localparam logic [2:0]        PosCenter = 3'd3;
  localparam logic [2:0]        PosMax    = 3'd6;
  localparam logic [2:0]        PosMin    = 3'd0;

  typedef enum logic [1:0] {StIdle, StCountdown, StPlay, StWin} state_e;

  state_e             r_state, w_state_d;
  logic [TickW-1:0]   r_tick_cnt, w_tick_cnt_d;
  logic [BlinkW-1:0]  r_blink_cnt, w_blink_cnt_d;
  logic               r_phase_on, w_phase_on_d;
  logic [2:0]         r_pos, w_pos_d;
  logic [1:0]         r_winner, w_winner_d;
  logic               r_btn_a, r_btn_b;
  logic [1:0]         r_led, w_led_d;
  logic [6:0]         r_score, w_score_d;
  logic               r_busy, w_busy_d;
  logic               w_press_a, w_press_b;

  assign w_press_a = i_btn_a & ~r_btn_a;
  assign w_press_b = i_btn_b & ~r_btn_b;

  always_comb begin
    w_state_d     = r_state;
    w_tick_cnt_d  = r_tick_cnt;
    w_blink_cnt_d = r_blink_cnt;
    w_phase_on_d  = r_phase_on;
    w_pos_d       = r_pos;
    w_winner_d    = r_winner;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d    = StCountdown;
          w_tick_cnt_d = '0;
          w_winner_d   = 2'b00;
          w_pos_d      = PosCenter;
        end
      end
      StCountdown: begin
        if (i_tick) begin
          if (r_tick_cnt == CountLast) begin
            w_state_d    = StPlay;
            w_tick_cnt_d = '0;
            w_pos_d      = PosCenter;
          end else begin
            w_tick_cnt_d = r_tick_cnt + 1'b1;
          end
        end
      end
      StPlay: begin
        if (w_press_a && !w_press_b && r_pos != PosMax) begin
          w_pos_d = r_pos + 3'd1;
        end else if (w_press_b && !w_press_a && r_pos != PosMin) begin
          w_pos_d = r_pos - 3'd1;
        end
        // Reaching either end wins on the same edge as the move.
        if (w_pos_d == PosMax || w_pos_d == PosMin) begin
          w_state_d     = StWin;
          w_winner_d    = (w_pos_d == PosMax) ? 2'b01 : 2'b10;
          w_tick_cnt_d  = '0;
          w_blink_cnt_d = '0;
          w_phase_on_d  = 1'b1;
        end
      end
      StWin: begin
        if (i_tick) begin
          if (r_tick_cnt == BlinkLast) begin
            w_tick_cnt_d = '0;
            w_phase_on_d = ~r_phase_on;
            if (r_blink_cnt == PhaseLast) begin
              w_state_d     = StIdle;
              w_blink_cnt_d = '0;
              w_pos_d       = PosCenter;
            end else begin
              w_blink_cnt_d = r_blink_cnt + 1'b1;
            end
          end else begin
            w_tick_cnt_d = r_tick_cnt + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next-state values so they register together with the state.
  always_comb begin
    w_led_d = 2'b00;
    unique case (w_state_d)
      StIdle:      w_led_d = 2'b00;
      StCountdown: w_led_d = 2'b01;
      StPlay:      w_led_d = 2'b10;
      StWin:       w_led_d = 2'b11;
      default:     w_led_d = 2'b00;
    endcase
    w_score_d = (w_state_d == StWin && !w_phase_on_d) ? 7'd0 : (7'd1 << w_pos_d);
    w_busy_d  = (w_state_d != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_tick_cnt  <= '0;
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
      r_pos       <= PosCenter;
      r_winner    <= 2'b00;
      r_btn_a     <= 1'b0;
      r_btn_b     <= 1'b0;
      r_led       <= 2'b00;
      r_score     <= 7'b0001000;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_tick_cnt  <= w_tick_cnt_d;
      r_blink_cnt <= w_blink_cnt_d;
      r_phase_on  <= w_phase_on_d;
      r_pos       <= w_pos_d;
      r_winner    <= w_winner_d;
      r_btn_a     <= i_btn_a;
      r_btn_b     <= i_btn_b;
      r_led       <= w_led_d;
      r_score     <= w_score_d;
      r_busy      <= w_busy_d;
    end
  end

  assign o_led_control = r_led;
  assign o_score       = r_score;
  assign o_winner      = r_winner;
  assign o_busy        = r_busy;

endmodule
